// File: rtl/adder_pkg.sv
// Shared sizing constants and the registered status-flag bundle for the adder datapath.
package adder_pkg;

    localparam int unsigned ADDER_WIDTH = 32;
    localparam int unsigned CLA_GROUP   = 4;
    localparam int unsigned NUM_GROUPS  = ADDER_WIDTH / CLA_GROUP;
    localparam int unsigned LA_BLOCK    = 4;

    typedef struct packed {
        logic ov;
        logic zf;
        logic nf;
        logic cf;
    } flags_t;

endpackage

// File: rtl/full_adder1_cla4.sv
// 4-bit carry-lookahead slice: sum bits, group generate/propagate, carry out,
// and the carry into bit 3 (used by the top slice for signed overflow).
module cla4
    import adder_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a,
    input  logic [CLA_GROUP-1:0] b,
    input  logic                 ci,
    output logic [CLA_GROUP-1:0] s,
    output logic                 G,
    output logic                 P,
    output logic                 co,
    output logic                 c3
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        G    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        P    = &p;
        co   = G | (P & ci);
        s    = p ^ c;
        c3   = c[3];
    end

endmodule

// File: rtl/full_adder1.sv
// Registered WIDTH-bit adder with carry-in: two-level carry lookahead over cla4
// slices, one output register holding sum, carry and OV/ZF/NF/CF flags.
module full_adder1
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Num_1,
    input  logic [WIDTH-1:0] Num_2,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             OV,
    output logic             ZF,
    output logic             NF,
    output logic             CF
);

    localparam int unsigned GROUPS = WIDTH / CLA_GROUP;

    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;
    logic [GROUPS-1:0] co_v;
    logic [GROUPS-1:0] c3_v;
    logic [GROUPS:0]   gc;
    logic [WIDTH-1:0]  sum_d;
    logic              cout_d;
    logic              msb_cin;
    logic              unused_ok;

    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    flags_t            flags_q;

    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_slice
        cla4 u_cla4 (
            .a  (Num_1[gi*CLA_GROUP +: CLA_GROUP]),
            .b  (Num_2[gi*CLA_GROUP +: CLA_GROUP]),
            .ci (gc[gi]),
            .s  (sum_d[gi*CLA_GROUP +: CLA_GROUP]),
            .G  (grp_g[gi]),
            .P  (grp_p[gi]),
            .co (co_v[gi]),
            .c3 (c3_v[gi])
        );
    end

    // Lookahead across groups within each LA_BLOCK-group block; the block's
    // carry-in is the previous block's last group carry, so blocks ripple.
    always_comb begin
        logic        term;
        logic        prod;
        int unsigned base;
        gc    = '0;
        gc[0] = Cin;
        for (int unsigned k = 0; k < GROUPS; k++) begin
            base = (k / LA_BLOCK) * LA_BLOCK;
            term = gc[base];
            for (int unsigned j = base; j <= k; j++) begin
                term = term & grp_p[j];
            end
            for (int unsigned j = base; j <= k; j++) begin
                prod = grp_g[j];
                for (int unsigned m = j + 1; m <= k; m++) begin
                    prod = prod & grp_p[m];
                end
                term = term | prod;
            end
            gc[k+1] = term;
        end
    end

    assign cout_d    = gc[GROUPS];
    assign msb_cin   = c3_v[GROUPS-1];
    assign unused_ok = &{1'b0, co_v};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            flags_q.ov <= msb_cin ^ cout_d;
            flags_q.zf <= (sum_d == '0);
            flags_q.nf <= sum_d[WIDTH-1];
            flags_q.cf <= cout_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign OV   = flags_q.ov;
    assign ZF   = flags_q.zf;
    assign NF   = flags_q.nf;
    assign CF   = flags_q.cf;

endmodule

// File: tb/tb_full_adder1.sv
// Self-checking bench for full_adder1: directed corner cases plus randomized
// back-to-back traffic against an arithmetic reference, with a mid-stream reset.
module tb_full_adder1;

    logic        Clk;
    logic        Rst;
    logic [31:0] Num_1;
    logic [31:0] Num_2;
    logic        Cin;
    logic [31:0] Sum;
    logic        Cout;
    logic        OV;
    logic        ZF;
    logic        NF;
    logic        CF;

    int checks   = 0;
    int failures = 0;

    full_adder1 #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Num_1 (Num_1),
        .Num_2 (Num_2),
        .Cin   (Cin),
        .Sum   (Sum),
        .Cout  (Cout),
        .OV    (OV),
        .ZF    (ZF),
        .NF    (NF),
        .CF    (CF)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Packed as {Sum, Cout, OV, ZF, NF, CF}.
    function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [32:0] full;
        longint      sv;
        logic        ov;
        full = {1'b0, a} + {1'b0, b} + {32'd0, c};
        sv   = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        ov   = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        return {full[31:0], full[32], ov, (full[31:0] == 32'd0), full[31], full[32]};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [36:0] obs;
        Rst   = 1'b1;
        Num_1 = 'x;
        Num_2 = $urandom;
        Cin   = 1'bx;
        for (int i = 0; i < 2; i++) begin
            tick();
            obs = {Sum, Cout, OV, ZF, NF, CF};
            checks++;
            if (obs !== 37'd0) begin
                failures++;
                $display("FAIL reset_cycle%0d got=%h expected=%h", i, obs, 37'd0);
            end
        end
        Rst   = 1'b0;
        Num_1 = 32'd0;
        Num_2 = 32'd0;
        Cin   = 1'b0;
        tick();
        obs = {Sum, Cout, OV, ZF, NF, CF};
        checks++;
        if (obs !== {32'd0, 5'b00100}) begin
            failures++;
            $display("FAIL reset_first_zero got=%h expected=%h", obs, {32'd0, 5'b00100});
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic        vc [5];
        logic [36:0] exp_v [5];
        logic [36:0] obs;
        va[0] = 32'h1;        vb[0] = 32'h2;        vc[0] = 1'b1; exp_v[0] = {32'h00000004, 5'b00000};
        va[1] = 32'h80000000; vb[1] = 32'hFFFFFF00; vc[1] = 1'b0; exp_v[1] = {32'h7FFFFF00, 5'b11001};
        va[2] = 32'h7FFFFFFF; vb[2] = 32'h0;        vc[2] = 1'b1; exp_v[2] = {32'h80000000, 5'b01010};
        va[3] = 32'hFFFFFFFF; vb[3] = 32'h0;        vc[3] = 1'b1; exp_v[3] = {32'h00000000, 5'b10101};
        va[4] = 32'h0000FFFF; vb[4] = 32'h00000001; vc[4] = 1'b0; exp_v[4] = {32'h00010000, 5'b00000};
        for (int i = 0; i < 5; i++) begin
            Num_1 = va[i];
            Num_2 = vb[i];
            Cin   = vc[i];
            tick();
            obs = {Sum, Cout, OV, ZF, NF, CF};
            checks++;
            if (obs !== exp_v[i]) begin
                failures++;
                $display("FAIL directed_%0d got=%h expected=%h", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [36:0] expv;
        logic [36:0] obs;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            c = 1'($urandom_range(0, 1));
            // Bias some operands toward carry/overflow/zero boundaries.
            if (i % 7 == 3) b = ~a;
            if (i % 11 == 5) a = 32'h7FFFFFFF;
            if (i % 13 == 6) b = -a;
            Num_1 = a;
            Num_2 = b;
            Cin   = c;
            Rst   = (i == 100) ? 1'b1 : 1'b0;
            expv  = Rst ? 37'd0 : model(a, b, c);
            tick();
            obs = {Sum, Cout, OV, ZF, NF, CF};
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL b2b_%0d a=%h b=%h c=%0d got=%h expected=%h", i, a, b, c, obs, expv);
            end
        end
        Rst = 1'b0;
    endtask

    initial begin
        Rst   = 1'b1;
        Num_1 = '0;
        Num_2 = '0;
        Cin   = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/full_adder1.md
Name: full_adder1

Overview:
- Registered 32-bit binary adder with carry-in; produces sum, carry-out and a four-flag status set (OV, ZF, NF, CF) for the datapath's ALU / flag register.
- Combinational carry-lookahead core followed by one output register stage. Single clock domain.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of 4 and at least 4.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- Num_1  input  WIDTH  operand A (unsigned or two's complement).
- Num_2  input  WIDTH  operand B.
- Cin  input  1  carry-in, added at bit 0.
- Sum  output  WIDTH  registered result, (Num_1 + Num_2 + Cin) mod 2^WIDTH.
- Cout  output  1  registered carry out of the MSB.
- OV  output  1  registered signed overflow.
- ZF  output  1  registered zero flag.
- NF  output  1  registered negative flag.
- CF  output  1  registered carry flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is Clk, reset port is Rst.
- Full sum: {Cout, Sum} = Num_1 + Num_2 + Cin, computed at WIDTH+1 bits, with no truncation before the carry is extracted.
- OV = (Num_1[MSB] == Num_2[MSB]) && (Sum[MSB] != Num_1[MSB]). Equivalently, OV = carry into MSB XOR carry out of MSB.
- ZF = 1 exactly when Sum == 0, including the case Cout = 1.
- NF = Sum[MSB].
- CF = Cout. This is an addition-only block: there is no borrow inversion.
- Latency: exactly 1 cycle. Inputs sampled on the rising edge of Clk appear on all outputs immediately after that edge.
- All outputs are updated together from the same sampled inputs, so no flag ever lags or leads Sum.
- There is no enable and no handshake. A new result is produced every cycle, giving full throughput.
- Reset, when Rst = 1 at a rising edge:
  - Sum = 0, Cout = 0, OV = 0, ZF = 0, NF = 0, CF = 0.
  - ZF is deliberately 0 in reset. It means "valid zero result", not "register empty".
- Reset dominates: if Rst is asserted mid-stream, that cycle's inputs are discarded.
- The first post-reset edge with Rst = 0 loads a normal result.
- Inputs are not registered separately; the only state is the output register.
- X on inputs while Rst = 1 must not propagate to outputs.

Decomposition:
- Shared package adder_pkg:
  - ADDER_WIDTH = 32.
  - CLA_GROUP = 4.
  - NUM_GROUPS = ADDER_WIDTH / CLA_GROUP.
- Sub-module cla4: 4-bit carry-lookahead slice.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], group generate G, group propagate P, co.
- full_adder1 instantiates WIDTH/4 cla4 slices.
- Group carries are formed by a second-level lookahead over G/P in 4-group blocks, rippling between blocks.
- The carry into the MSB is taken from the top slice's internal bit-3 carry-in, for OV.

Test Plan:
- Reset: assert Rst with any inputs for 2 cycles -> all outputs 0, including ZF = 0. Deassert with Num_1 = 0, Num_2 = 0, Cin = 0 -> next cycle Sum = 0, ZF = 1, Cout = OV = NF = CF = 0.
- Small add: Num_1 = 1, Num_2 = 2, Cin = 1 -> one cycle later Sum = 0x00000004, all flags 0, Cout = 0.
- Negative + negative: Num_1 = 0x80000000, Num_2 = 0xFFFFFF00, Cin = 0 -> Sum = 0x7FFFFF00, Cout = 1, CF = 1, OV = 1, NF = 0, ZF = 0.
- Positive overflow: Num_1 = 0x7FFFFFFF, Num_2 = 0, Cin = 1 -> Sum = 0x80000000, OV = 1, NF = 1, Cout = 0, ZF = 0.
- Wrap to zero: Num_1 = 0xFFFFFFFF, Num_2 = 0, Cin = 1 -> Sum = 0, Cout = 1, CF = 1, ZF = 1, OV = 0, NF = 0.
- Back-to-back and reset mid-stream: change inputs every cycle with random values and compare against a 33-bit reference model with 1-cycle delay. Assert Rst for one cycle mid-stream -> outputs 0 that cycle, and correct results resume on the next edge.
